// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit, ALU and datapath.
package mc_pkg;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;
    localparam logic [3:0] ALU_SQR = 4'b1011;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_SQR = 6'b111000;
    localparam logic [5:0] FN_JR  = 6'b001000;

    // Sequencer states
    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    // Instruction classes produced by the decoder
    typedef enum logic [3:0] {
        C_RTYPE, C_ALUI, C_LOAD, C_STORE, C_BRANCH,
        C_JUMP, C_JAL, C_JR, C_ILLEGAL
    } iclass_t;

    // ALU A select
    localparam logic [1:0] A_PC    = 2'd0;
    localparam logic [1:0] A_RS    = 2'd1;
    localparam logic [1:0] A_SHAMT = 2'd2;
    // ALU B select
    localparam logic [1:0] B_RT    = 2'd0;
    localparam logic [1:0] B_FOUR  = 2'd1;
    localparam logic [1:0] B_IMM   = 2'd2;
    localparam logic [1:0] B_IMM2  = 2'd3;
    // PC source
    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_RS     = 2'd3;
    // Register write address
    localparam logic [1:0] DST_RT  = 2'd0;
    localparam logic [1:0] DST_RD  = 2'd1;
    localparam logic [1:0] DST_R31 = 2'd2;
    // Register write data
    localparam logic [1:0] WD_ALUOUT = 2'd0;
    localparam logic [1:0] WD_MDR    = 2'd1;
    localparam logic [1:0] WD_PC     = 2'd2;
    // Memory address and immediate extension
    localparam logic IOR_PC     = 1'b0;
    localparam logic IOR_ALUOUT = 1'b1;
    localparam logic EXT_ZERO   = 1'b0;
    localparam logic EXT_SIGN   = 1'b1;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: class, execute-stage ALU code and extension mode.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output iclass_t    cls,
    output logic [3:0] aluc,
    output logic       sext
);

    // Map {op, func} to class, ALU operation and immediate extension
    always_comb begin
        cls  = C_ILLEGAL;
        aluc = ALU_ADD;
        sext = EXT_SIGN;
        case (op)
            OP_RTYPE: begin
                cls = C_RTYPE;
                case (func)
                    FN_ADD:  aluc = ALU_ADD;
                    FN_SUB:  aluc = ALU_SUB;
                    FN_AND:  aluc = ALU_AND;
                    FN_OR:   aluc = ALU_OR;
                    FN_XOR:  aluc = ALU_XOR;
                    FN_SLL:  aluc = ALU_SLL;
                    FN_SRL:  aluc = ALU_SRL;
                    FN_SRA:  aluc = ALU_SRA;
                    FN_SQR:  aluc = ALU_SQR;
                    FN_JR:   cls  = C_JR;
                    default: cls  = C_ILLEGAL;
                endcase
            end
            OP_ADDI: begin cls = C_ALUI; aluc = ALU_ADD; end
            OP_ANDI: begin cls = C_ALUI; aluc = ALU_AND; sext = EXT_ZERO; end
            OP_ORI:  begin cls = C_ALUI; aluc = ALU_OR;  sext = EXT_ZERO; end
            OP_XORI: begin cls = C_ALUI; aluc = ALU_XOR; sext = EXT_ZERO; end
            OP_LUI:  begin cls = C_ALUI; aluc = ALU_LUI; end
            OP_LW:   cls = C_LOAD;
            OP_SW:   cls = C_STORE;
            OP_BEQ, OP_BNE: begin cls = C_BRANCH; aluc = ALU_SUB; end
            OP_J:    cls = C_JUMP;
            OP_JAL:  cls = C_JAL;
            default: cls = C_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS control unit: IF/ID/EXE/MEM/WB sequencer and datapath control outputs.
module mc_control
    import mc_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       z,
    output logic [3:0] aluc,
    output logic [1:0] alu_a_sel,
    output logic [1:0] alu_b_sel,
    output logic       sext,
    output logic       pc_wr,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       ir_wr,
    output logic       mem_wr,
    output logic       reg_wr,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic       illegal
);

    state_t     state;
    iclass_t    cls;
    logic [3:0] exe_aluc;
    logic       exe_sext;

    mc_decode u_decode (
        .op   (op),
        .func (func),
        .cls  (cls),
        .aluc (exe_aluc),
        .sext (exe_sext)
    );

    // State sequencing; undefined encodings fall back to IF
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IF;
        end else begin
            case (state)
                S_IF: state <= S_ID;
                S_ID: begin
                    case (cls)
                        C_JUMP, C_JAL, C_JR, C_ILLEGAL: state <= S_IF;
                        default:                        state <= S_EXE;
                    endcase
                end
                S_EXE: begin
                    case (cls)
                        C_RTYPE, C_ALUI:  state <= S_WB;
                        C_LOAD, C_STORE:  state <= S_MEM;
                        default:          state <= S_IF;
                    endcase
                end
                S_MEM:   state <= (cls == C_LOAD) ? S_WB : S_IF;
                S_WB:    state <= S_IF;
                default: state <= S_IF;
            endcase
        end
    end

    // Per-state datapath controls; write enables are masked while reset is high
    always_comb begin
        aluc      = ALU_ADD;
        alu_a_sel = A_PC;
        alu_b_sel = B_RT;
        sext      = EXT_ZERO;
        pc_wr     = 1'b0;
        pc_src    = PC_ALU;
        iord      = IOR_PC;
        ir_wr     = 1'b0;
        mem_wr    = 1'b0;
        reg_wr    = 1'b0;
        reg_dst   = DST_RT;
        wd_sel    = WD_ALUOUT;
        illegal   = 1'b0;
        case (state)
            S_IF: begin
                alu_b_sel = B_FOUR;
                ir_wr     = 1'b1;
                pc_wr     = 1'b1;
            end
            S_ID: begin
                alu_b_sel = B_IMM2;
                sext      = EXT_SIGN;
                case (cls)
                    C_JUMP: begin pc_wr = 1'b1; pc_src = PC_JUMP; end
                    C_JAL: begin
                        pc_wr   = 1'b1;
                        pc_src  = PC_JUMP;
                        reg_wr  = 1'b1;
                        reg_dst = DST_R31;
                        wd_sel  = WD_PC;
                    end
                    C_JR:      begin pc_wr = 1'b1; pc_src = PC_RS; end
                    C_ILLEGAL: illegal = 1'b1;
                    default: ;
                endcase
            end
            S_EXE: begin
                aluc      = exe_aluc;
                alu_a_sel = A_RS;
                case (cls)
                    C_RTYPE: begin
                        if (exe_aluc == ALU_SLL || exe_aluc == ALU_SRL || exe_aluc == ALU_SRA)
                            alu_a_sel = A_SHAMT;
                    end
                    C_ALUI, C_LOAD, C_STORE: begin
                        alu_b_sel = B_IMM;
                        sext      = exe_sext;
                    end
                    C_BRANCH: begin
                        pc_src = PC_ALUOUT;
                        pc_wr  = (op == OP_BNE) ? ~z : z;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                iord   = IOR_ALUOUT;
                mem_wr = (cls == C_STORE);
            end
            S_WB: begin
                reg_wr = 1'b1;
                case (cls)
                    C_RTYPE: reg_dst = DST_RD;
                    C_LOAD:  wd_sel  = WD_MDR;
                    default: ;
                endcase
            end
            default: ;
        endcase
        if (reset) begin
            pc_wr   = 1'b0;
            ir_wr   = 1'b0;
            mem_wr  = 1'b0;
            reg_wr  = 1'b0;
            illegal = 1'b0;
        end
    end

endmodule
